dma_master: RTL and testbench
=============================

Name: dma_master

Overview:
- Single-channel word-copy DMA engine that occupies the currently tied-off bus master slot m2.
- Acts as a bus initiator towards the existing slaves (ROM, timer, UART, GPIO) and as a slave for its own configuration registers (slave slot s5).
- Copies COUNT 32-bit words from a source word address to a destination word address, one read then one write per word.
- Releases the bus between words so the CPU fetch and memory masters are not starved, and raises an interrupt on completion.

Parameters:
- CNT_W, 16, width of the word-count register; maximum transfer is 2^CNT_W-1 words.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- cs_  input  1  slave chip select, active-low
- as_  input  1  slave address strobe, active-low
- rw  input  1  slave access direction, `READ/`WRITE
- addr  input  2  slave register select (word address bits [1:0])
- wr_data  input  32  slave write data
- rd_data  output  32  slave read data
- rdy_  output  1  slave ready, active-low
- m_req_  output  1  bus request, active-low
- m_grnt_  input  1  bus grant, active-low
- m_addr  output  30  master word address
- m_as_  output  1  master address strobe, active-low
- m_rw  output  1  master direction
- m_wr_data  output  32  master write data
- m_rd_data  input  32  shared master read data
- m_rdy_  input  1  shared master ready, active-low
- irq  output  1  completion interrupt, level, active-high

Behaviour:
- Reset values:
  - m_req_=1, m_as_=1, m_rw=`READ, m_addr=0, m_wr_data=0
  - rd_data=0, rdy_=1, irq=0
  - all registers 0; FSM in IDLE.
- Registers (addr):
  - 0 CTRL: bit0 START/BUSY, bit1 IE, bit2 DONE (write-1-to-clear)
  - 1 SRC (30 bits)
  - 2 DST (30 bits)
  - 3 COUNT (CNT_W bits)
- Slave access:
  - When cs_=0 and as_=0, the access completes with rdy_=0 on the next cycle, for exactly one cycle.
  - rd_data is valid in that same cycle and is 0 whenever rdy_=1.
  - Reads of SRC, DST and COUNT return their live values while a transfer runs.
  - Writes to SRC, DST and COUNT while BUSY are ignored.
- START:
  - Writing CTRL bit0=1 while idle starts a transfer.
  - If COUNT=0, DONE is set the next cycle and no bus request is made.
  - Writing bit0=0 while BUSY aborts at the next word boundary (after the current write completes, or immediately if still in REQ). An abort sets DONE.
- FSM states: IDLE, REQ, RD, WR, NEXT.
  - IDLE→REQ on start with COUNT≠0.
  - REQ: m_req_=0. Move to RD on the first cycle m_grnt_=0.
  - RD: m_as_=0, m_rw=`READ, m_addr=SRC. On m_rdy_=0, latch m_rd_data and go to WR.
  - WR: m_as_=0, m_rw=`WRITE, m_addr=DST, m_wr_data=latched word. On m_rdy_=0 go to NEXT.
  - NEXT: m_req_=1 and m_as_=1. SRC+=1, DST+=1, COUNT-=1. If the new COUNT=0 or an abort is pending, go to IDLE with DONE set and BUSY cleared; otherwise go to REQ.
- Bus handshake:
  - m_req_ is held low from REQ through WR.
  - m_as_ is held low until m_rdy_ is sampled low, so slave wait states of any length are tolerated.
  - The bus is released for at least one cycle per word.
- Address wrap: SRC and DST wrap modulo 2^30 with no error.
- irq = DONE & IE, combinational from registers. Clearing DONE or IE deasserts irq in the same cycle as the register update.
- Simultaneous events: if a DONE set and a CPU write-1-clear of DONE land in the same cycle, the set wins.
- Reset mid-transfer: immediate return to IDLE with the bus released asynchronously.

Optional Feature:
- Macro: DMA_FIXED_ADDR_EN.
- When defined: CTRL bit3 FIXSRC and bit4 FIXDST suppress the SRC and DST increment respectively, for FIFO-style peripherals such as the UART data register.
- When undefined: bits 3 and 4 read as 0, writes to them are ignored, and both addresses always increment.

Decomposition:
- Shared package/header holds:
  - register offsets DMA_CTRL/SRC/DST/COUNT
  - CTRL bit positions
  - FSM state encoding
  - existing word address and data widths
  - `READ/`WRITE and enable macros.
- One natural sub-module, dma_ctrl_regs: the slave register file, access handshake, DONE/irq logic. The FSM and bus master logic stay in the top.

Test Plan:
- SRC=0x100, DST=0x200, COUNT=3, IE=1, START; zero-wait slave → three read/write pairs at 0x100/0x200, 0x101/0x201, 0x102/0x202; data copied intact; m_req_ deasserts between words; irq=1 after the last write; COUNT reads 0.
- Same transfer with the slave inserting 4 wait cycles and the arbiter delaying grant by 5 cycles → m_as_ and m_addr stay stable until m_rdy_=0; final memory contents identical.
- COUNT=0 with START → no m_req_ activity; DONE=1 after one cycle; irq follows IE.
- COUNT=10, START, then write CTRL=0 during word 2's RD → word 2 write completes, no word 3 request, DONE=1, COUNT reads 7.
- SRC=0x3FFFFFFF, COUNT=2 → second read at address 0x0.
- Assert reset during WR → m_req_=1, m_as_=1, irq=0 immediately; all registers read 0 after reset.
- With DMA_FIXED_ADDR_EN: FIXSRC=1, COUNT=4 → all reads at SRC, DST increments by 4.

Source files
------------

// File: rtl/dma_master_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine.
// Optional build macro: DMA_FIXED_ADDR_EN (CTRL FIXSRC/FIXDST bits).
`ifndef DMA_MASTER_PKG_SV
`define DMA_MASTER_PKG_SV

`ifndef READ
`define READ    1'b1
`endif
`ifndef WRITE
`define WRITE   1'b0
`endif
`ifndef ENABLE_
`define ENABLE_  1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

package dma_master_pkg;
  localparam int WORD_ADDR_W = 30;
  localparam int DATA_W      = 32;

  localparam logic [1:0] DMA_CTRL  = 2'd0;
  localparam logic [1:0] DMA_SRC   = 2'd1;
  localparam logic [1:0] DMA_DST   = 2'd2;
  localparam logic [1:0] DMA_COUNT = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_FIXSRC = 3;
  localparam int CTRL_FIXDST = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_NEXT = 3'd4
  } dma_state_e;
endpackage

`endif

// File: rtl/dma_ctrl_regs.sv
// DMA configuration slave: CTRL/SRC/DST/COUNT, one-cycle access handshake,
// DONE/abort bookkeeping and the level interrupt.
// Optional build macro: DMA_FIXED_ADDR_EN adds CTRL FIXSRC/FIXDST.
module dma_ctrl_regs
  import dma_master_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cs_,
  input  logic                   i_as_,
  input  logic                   i_rw,
  input  logic [1:0]             i_addr,
  input  logic [DATA_W-1:0]      i_wr_data,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic                   o_rdy_,
  input  logic                   i_step,
  input  logic                   i_fin,
  output logic                   o_busy,
  output logic                   o_abort,
  output logic [WORD_ADDR_W-1:0] o_src,
  output logic [WORD_ADDR_W-1:0] o_dst,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_irq
);
  logic                   r_ack, r_busy, r_ie, r_done, r_abort;
  logic [WORD_ADDR_W-1:0] r_src, r_dst;
  logic [CNT_W-1:0]       r_count;
  logic [DATA_W-1:0]      r_rd_data, w_rdata, w_ctrl;
  logic                   w_acc, w_wr, w_ctrl_wr, w_cfg_wr, w_fixsrc, w_fixdst;
  logic                   w_unused;

  // An access is taken once per strobe; the ack cycle itself cannot start another.
  assign w_acc     = ~i_cs_ & ~i_as_ & ~r_ack;
  assign w_wr      = w_acc & (i_rw == `WRITE);
  assign w_ctrl_wr = w_wr & (i_addr == DMA_CTRL);
  assign w_cfg_wr  = w_wr & ~r_busy;
  assign w_unused  = &{1'b0, i_wr_data[DATA_W-1:WORD_ADDR_W]};

`ifdef DMA_FIXED_ADDR_EN
  logic r_fixsrc, r_fixdst;
  // Fixed-address mode bits only change while idle so a running copy is stable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fixsrc <= 1'b0;
      r_fixdst <= 1'b0;
    end else if (w_ctrl_wr && !r_busy) begin
      r_fixsrc <= i_wr_data[CTRL_FIXSRC];
      r_fixdst <= i_wr_data[CTRL_FIXDST];
    end
  end
  assign w_fixsrc = r_fixsrc;
  assign w_fixdst = r_fixdst;
`else
  assign w_fixsrc = 1'b0;
  assign w_fixdst = 1'b0;
`endif

  // Read mux over the live register values.
  always_comb begin
    w_ctrl              = '0;
    w_ctrl[CTRL_START]  = r_busy;
    w_ctrl[CTRL_IE]     = r_ie;
    w_ctrl[CTRL_DONE]   = r_done;
    w_ctrl[CTRL_FIXSRC] = w_fixsrc;
    w_ctrl[CTRL_FIXDST] = w_fixdst;
    w_rdata             = '0;
    case (i_addr)
      DMA_CTRL:  w_rdata = w_ctrl;
      DMA_SRC:   w_rdata[WORD_ADDR_W-1:0] = r_src;
      DMA_DST:   w_rdata[WORD_ADDR_W-1:0] = r_dst;
      DMA_COUNT: w_rdata[CNT_W-1:0] = r_count;
      default:   w_rdata = '0;
    endcase
  end

  // Ready pulse and read data for exactly the cycle after the strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ack     <= w_acc;
      r_rd_data <= (w_acc && i_rw == `READ) ? w_rdata : '0;
    end
  end

  // START/abort/IE/DONE; a completion beats a same-cycle DONE clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_abort <= 1'b0;
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (i_fin) begin
        r_busy  <= 1'b0;
        r_abort <= 1'b0;
      end else if (w_ctrl_wr) begin
        if (i_wr_data[CTRL_START] && !r_busy) begin
          r_busy  <= 1'b1;
          r_abort <= 1'b0;
        end else if (!i_wr_data[CTRL_START] && r_busy) begin
          r_abort <= 1'b1;
        end
      end
      if (w_ctrl_wr) r_ie <= i_wr_data[CTRL_IE];
      if (i_fin) r_done <= 1'b1;
      else if (w_ctrl_wr && i_wr_data[CTRL_DONE]) r_done <= 1'b0;
    end
  end

  // Address/count registers: engine steps them per word, CPU writes only while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
    end else if (i_step) begin
      if (!w_fixsrc) r_src <= r_src + 1'b1;
      if (!w_fixdst) r_dst <= r_dst + 1'b1;
      r_count <= r_count - 1'b1;
    end else if (w_cfg_wr) begin
      case (i_addr)
        DMA_SRC:   r_src   <= i_wr_data[WORD_ADDR_W-1:0];
        DMA_DST:   r_dst   <= i_wr_data[WORD_ADDR_W-1:0];
        DMA_COUNT: r_count <= i_wr_data[CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_rdy_    = ~r_ack;
  assign o_busy    = r_busy;
  assign o_abort   = r_abort;
  assign o_src     = r_src;
  assign o_dst     = r_dst;
  assign o_count   = r_count;
  assign o_irq     = r_done & r_ie;
endmodule

// File: rtl/dma_master.sv
// Single-channel word-copy DMA: bus master FSM (read word, write word,
// release bus) around the dma_ctrl_regs configuration slave.
// Optional build macro: DMA_FIXED_ADDR_EN (handled inside dma_ctrl_regs).
module dma_master
  import dma_master_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [1:0]             addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rdy_,
  output logic                   m_req_,
  input  logic                   m_grnt_,
  output logic [WORD_ADDR_W-1:0] m_addr,
  output logic                   m_as_,
  output logic                   m_rw,
  output logic [DATA_W-1:0]      m_wr_data,
  input  logic [DATA_W-1:0]      m_rd_data,
  input  logic                   m_rdy_,
  output logic                   irq
);
  dma_state_e             r_state, w_next;
  logic [DATA_W-1:0]      r_data;
  logic                   w_step, w_fin, w_busy, w_abort;
  logic [WORD_ADDR_W-1:0] w_src, w_dst;
  logic [CNT_W-1:0]       w_count;

  dma_ctrl_regs #(.CNT_W(CNT_W)) u_regs (
    .i_clk(clk), .i_rst(reset), .i_cs_(cs_), .i_as_(as_), .i_rw(rw),
    .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd_data), .o_rdy_(rdy_),
    .i_step(w_step), .i_fin(w_fin), .o_busy(w_busy), .o_abort(w_abort),
    .o_src(w_src), .o_dst(w_dst), .o_count(w_count), .o_irq(irq)
  );

  // State register; reset drops straight to IDLE, releasing the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Word buffer between the read and write halves of a copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_data <= '0;
    else if (r_state == ST_RD && !m_rdy_) r_data <= m_rd_data;
  end

  // Next state and bus outputs; strobe holds until the slave's ready is seen.
  always_comb begin
    w_next    = r_state;
    w_step    = 1'b0;
    w_fin     = 1'b0;
    m_req_    = `DISABLE_;
    m_as_     = `DISABLE_;
    m_rw      = `READ;
    m_addr    = '0;
    m_wr_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_busy) begin
          if (w_count == '0 || w_abort) w_fin = 1'b1;
          else                          w_next = ST_REQ;
        end
      end
      ST_REQ: begin
        m_req_ = `ENABLE_;
        if (w_abort) begin
          w_fin  = 1'b1;
          w_next = ST_IDLE;
        end else if (!m_grnt_) begin
          w_next = ST_RD;
        end
      end
      ST_RD: begin
        m_req_ = `ENABLE_;
        m_as_  = `ENABLE_;
        m_addr = w_src;
        if (!m_rdy_) w_next = ST_WR;
      end
      ST_WR: begin
        m_req_    = `ENABLE_;
        m_as_     = `ENABLE_;
        m_rw      = `WRITE;
        m_addr    = w_dst;
        m_wr_data = r_data;
        if (!m_rdy_) w_next = ST_NEXT;
      end
      ST_NEXT: begin
        w_step = 1'b1;
        if (w_count == CNT_W'(1) || w_abort) begin
          w_fin  = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_next = ST_REQ;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: random word-copy transfers against a
// list-of-accesses reference model, plus wait states, abort, wrap and reset.
module tb_dma_master;
`ifdef DMA_FIXED_ADDR_EN
  localparam bit FIX_EN = 1'b1;
`else
  localparam bit FIX_EN = 1'b0;
`endif

  logic        clk, reset, cs_, as_, rw, rdy_, m_req_, m_grnt_, m_as_, m_rw, m_rdy_, irq;
  logic [1:0]  addr;
  logic [31:0] wr_data, rd_data, m_wr_data, m_rd_data;
  logic [29:0] m_addr;

  int checks = 0;
  int errors = 0;
  int w_dly = 0;
  int g_dly = 0;
  int wcnt, gcnt;
  int req_rel = 0;
  int req_fall = 0;
  logic [31:0] seed;
  logic        q_rw[$];
  logic [29:0] q_addr[$];
  logic [31:0] q_data[$];

  dma_master #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .m_req_(m_req_),
    .m_grnt_(m_grnt_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_rdy_(m_rdy_), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [29:0] a);
    return {a, 2'b01} ^ seed;
  endfunction

  // Arbiter model: grant after g_dly extra cycles of request.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt <= 0; m_grnt_ <= 1'b1;
    end else if (m_req_) begin
      gcnt <= 0; m_grnt_ <= 1'b1;
    end else if (gcnt >= g_dly) begin
      m_grnt_ <= 1'b0;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  // Slave model with w_dly wait states; logs every completed access.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rdy_ <= 1'b1; wcnt <= 0; m_rd_data <= '0;
    end else begin
      m_rdy_ <= 1'b1;
      if (!m_as_ && m_rdy_) begin
        if (wcnt >= w_dly) begin
          m_rdy_ <= 1'b0;
          wcnt   <= 0;
          if (m_rw) m_rd_data <= rom(m_addr);
          q_rw.push_back(m_rw);
          q_addr.push_back(m_addr);
          q_data.push_back(m_rw ? rom(m_addr) : m_wr_data);
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  // Monitor: strobe/address stability during an access and request edges.
  initial begin
    logic        act, prev_req, lat_rw;
    logic [29:0] lat_addr;
    act = 1'b0; prev_req = 1'b1; lat_rw = 1'b1; lat_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset && !m_as_) begin
        if (act) begin
          checks++;
          if (m_addr !== lat_addr || m_rw !== lat_rw) begin
            errors++;
            $display("FAIL bus_stable: addr=%h rw=%b, held %h/%b", m_addr, m_rw, lat_addr, lat_rw);
          end
        end else begin
          lat_addr = m_addr; lat_rw = m_rw; act = 1'b1;
        end
        if (!m_rdy_) act = 1'b0;
      end else begin
        act = 1'b0;
      end
      if (!prev_req && m_req_) req_rel++;
      if (prev_req && !m_req_) req_fall++;
      prev_req = m_req_;
    end
  end

  task automatic wait_rdy(input string nm, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!rdy_) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no rdy_ within 16 cycles", nm);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    logic ok;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    wait_rdy("cpu_write", ok);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    logic ok;
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    wait_rdy("cpu_read", ok);
    d = rd_data;
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic check_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: read %h, expected %h", nm, d, exp);
    end
  endtask

  task automatic wait_irq(input string nm, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (irq) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_irq: irq=%b after %0d cycles, expected 1", nm, irq, limit);
    end
  endtask

  // Reference: n words, each a read of the source word then a write of it.
  task automatic check_log(input string nm, input logic [29:0] src, dst, input int n, input bit fs, fd);
    logic [29:0] ra, wa;
    checks++;
    if (q_addr.size() != 2 * n) begin
      errors++;
      $display("FAIL %s_len: %0d accesses, expected %0d", nm, q_addr.size(), 2 * n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ra = fs ? src : src + 30'(i);
        wa = fd ? dst : dst + 30'(i);
        checks++;
        if (q_rw[2*i] !== 1'b1 || q_addr[2*i] !== ra || q_rw[2*i+1] !== 1'b0 ||
            q_addr[2*i+1] !== wa || q_data[2*i+1] !== rom(ra)) begin
          errors++;
          $display("FAIL %s_word%0d: rd %b@%h wr %b@%h data %h, expected rd@%h wr@%h data %h",
                   nm, i, q_rw[2*i], q_addr[2*i], q_rw[2*i+1], q_addr[2*i+1], q_data[2*i+1],
                   ra, wa, rom(ra));
        end
      end
    end
  endtask

  task automatic clear_log();
    q_rw.delete(); q_addr.delete(); q_data.delete();
    req_rel = 0; req_fall = 0;
  endtask

  task automatic run_xfer(input string nm, input logic [29:0] src, dst, input int cnt,
                          input logic [31:0] extra, input int w, g, input bit fs, fd);
    logic [29:0] es, ed;
    w_dly = w; g_dly = g;
    clear_log();
    cpu_write(2'd1, {2'b0, src});
    cpu_write(2'd2, {2'b0, dst});
    cpu_write(2'd3, 32'(cnt));
    cpu_write(2'd0, 32'h3 | extra);
    wait_irq(nm, 4000);
    check_log(nm, src, dst, cnt, fs, fd);
    checks++;
    if (req_rel != cnt) begin
      errors++;
      $display("FAIL %s_release: %0d bus releases, expected %0d", nm, req_rel, cnt);
    end
    es = fs ? src : src + 30'(cnt);
    ed = fd ? dst : dst + 30'(cnt);
    check_reg({nm, "_count"}, 2'd3, 32'd0);
    check_reg({nm, "_src"}, 2'd1, {2'b0, es});
    check_reg({nm, "_dst"}, 2'd2, {2'b0, ed});
    check_reg({nm, "_ctrl"}, 2'd0, 32'h6 | (FIX_EN ? (extra & 32'h18) : 32'h0));
    cpu_write(2'd0, 32'h4);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL %s_irqclr: irq=%b, expected 0", nm, irq);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (m_req_ !== 1'b1 || m_as_ !== 1'b1 || m_rw !== 1'b1 || m_addr !== 30'd0 ||
        m_wr_data !== 32'd0 || rd_data !== 32'd0 || rdy_ !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: req=%b as=%b rw=%b addr=%h wd=%h rd=%h rdy=%b irq=%b, expected 1 1 1 0 0 0 1 0",
               m_req_, m_as_, m_rw, m_addr, m_wr_data, rd_data, rdy_, irq);
    end
    for (int a = 0; a < 4; a++) check_reg("reset_reg", 2'(a), 32'd0);
    @(negedge clk);
    checks++;
    if (rdy_ !== 1'b1 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL rdy_pulse: rdy_=%b rd_data=%h one cycle later, expected 1 / 0", rdy_, rd_data);
    end
  endtask

  task automatic test_basic();
    run_xfer("basic", 30'h100, 30'h200, 3, 32'h0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_xfer("wait", 30'h100, 30'h200, 3, 32'h0, 4, 5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      run_xfer("rand", 30'($urandom), 30'($urandom), $urandom_range(1, 5), 32'h0,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
  endtask

  task automatic test_zero_count();
    clear_log();
    cpu_write(2'd3, 32'd0);
    cpu_write(2'd0, 32'h3);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL zero_early: irq=%b in start ack cycle, expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: irq=%b one cycle later, expected 1", irq);
    end
    check_reg("zero_ctrl", 2'd0, 32'h6);
    repeat (5) @(negedge clk);
    checks++;
    if (req_fall != 0) begin
      errors++;
      $display("FAIL zero_noreq: %0d bus requests, expected 0", req_fall);
    end
    cpu_write(2'd0, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL zero_ie_off: irq=%b, expected 0", irq);
    end
    check_reg("zero_done_kept", 2'd0, 32'h4);
    cpu_write(2'd0, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL zero_ie_on: irq=%b, expected 1", irq);
    end
    cpu_write(2'd0, 32'h6);
    check_reg("zero_w1c", 2'd0, 32'h2);
    cpu_write(2'd0, 32'h0);
  endtask

  task automatic test_abort();
    logic [29:0] src, dst;
    logic        seen;
    src = 30'($urandom); dst = 30'($urandom);
    w_dly = 3; g_dly = 1;
    clear_log();
    cpu_write(2'd1, {2'b0, src});
    cpu_write(2'd2, {2'b0, dst});
    cpu_write(2'd3, 32'd10);
    cpu_write(2'd0, 32'h3);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q_addr.size() == 4 && !m_as_ && m_rw) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_sync: word 2 read not observed, log size %0d", q_addr.size());
    end
    check_reg("abort_live_count", 2'd3, 32'd8);
    cpu_write(2'd1, 32'h0);
    cpu_write(2'd0, 32'h2);
    wait_irq("abort", 2000);
    repeat (4) @(negedge clk);
    check_log("abort", src, dst, 3, 1'b0, 1'b0);
    checks++;
    if (req_rel != 3) begin
      errors++;
      $display("FAIL abort_release: %0d bus releases, expected 3", req_rel);
    end
    check_reg("abort_count", 2'd3, 32'd7);
    check_reg("abort_src", 2'd1, {2'b0, src + 30'd3});
    check_reg("abort_ctrl", 2'd0, 32'h6);
    cpu_write(2'd0, 32'h4);
  endtask

  task automatic test_wrap();
    run_xfer("wrap", 30'h3FFFFFFF, 30'h3FFFFFFF, 2, 32'h0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fixed();
`ifdef DMA_FIXED_ADDR_EN
    run_xfer("fixsrc", 30'h40, 30'h300, 4, 32'h8, 1, 1, 1'b1, 1'b0);
    run_xfer("fixdst", 30'h500, 30'h44, 3, 32'h10, 0, 2, 1'b0, 1'b1);
`else
    cpu_write(2'd0, 32'h1A);
    check_reg("fix_ignored", 2'd0, 32'h2);
    run_xfer("nofix", 30'h40, 30'h300, 4, 32'h18, 1, 1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    logic seen;
    w_dly = 3; g_dly = 0;
    cpu_write(2'd3, 32'd0);
    cpu_write(2'd0, 32'h3);
    @(negedge clk);
    clear_log();
    cpu_write(2'd1, 32'h80);
    cpu_write(2'd2, 32'h90);
    cpu_write(2'd3, 32'd5);
    cpu_write(2'd0, 32'h3);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_as_ && !m_rw) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || irq !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: write phase seen=%b irq=%b, expected 1 1", seen, irq);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (m_req_ !== 1'b1 || m_as_ !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bus: req=%b as=%b irq=%b, expected 1 1 0", m_req_, m_as_, irq);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) check_reg("rstmid_reg", 2'(a), 32'd0);
    checks++;
    if (m_req_ !== 1'b1 || m_addr !== 30'd0 || m_wr_data !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_idle: req=%b addr=%h wd=%h, expected 1 0 0", m_req_, m_addr, m_wr_data);
    end
  endtask

  initial begin
    seed = $urandom;
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wait_states();
    test_zero_count();
    test_abort();
    test_wrap();
    test_fixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
